ir_encoder: RTL

IR_ENCODER -- requirements
Module: ir_encoder

---
 rtl/ir_pkg.sv | 29 ++
 rtl/ir_carrier_gen.sv | 30 +++
 rtl/ir_encoder.sv | 119 +++++++++++
 3 files changed

// File: rtl/ir_pkg.sv
// Shared NEC IR definitions: FSM states, protocol durations in units, and the unit-length formula.
// Used by the encoder and by the matching decoder.
`timescale 1ns/1ps
package ir_pkg;

    typedef enum logic [2:0] {
        IR_IDLE,
        IR_LEAD_MARK,
        IR_LEAD_SPACE,
        IR_BIT_MARK,
        IR_BIT_SPACE,
        IR_STOP_MARK,
        IR_GAP
    } ir_state_e;

    localparam int LEAD_MARK_UNITS  = 16;
    localparam int LEAD_SPACE_UNITS = 8;
    localparam int RPT_SPACE_UNITS  = 4;
    localparam int BIT_MARK_UNITS   = 1;
    localparam int ZERO_SPACE_UNITS = 1;
    localparam int ONE_SPACE_UNITS  = 3;
    localparam int STOP_MARK_UNITS  = 1;

    // One NEC unit is 562.5 us, i.e. 9/16000 s; widened so fast clocks cannot overflow.
    function automatic int unit_cycles(input int clk_hz);
        return int'((longint'(clk_hz) * 64'sd9) / 64'sd16000);
    endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Mark carrier: period car_cyc clocks, high for the first car_cyc/3 clocks of each period.
// restart holds the phase at zero so every mark begins with a fresh high phase.
`timescale 1ns/1ps
`ifdef IR_ENCODER_CARRIER_EN
module ir_carrier_gen #(
    parameter int car_cyc = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic carrier
);
    localparam int W = (car_cyc > 1) ? $clog2(car_cyc) : 1;

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt_q <= '0;
        end else if (cnt_q == W'(car_cyc - 1)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign carrier = (cnt_q < W'(car_cyc / 3));

endmodule
`endif

// File: rtl/ir_encoder.sv
// NEC IR frame encoder: lead mark/space, 32 data bits LSB first (or a repeat code), stop mark, idle gap.
// Macro IR_ENCODER_CARRIER_EN: marks carry a modulated carrier; otherwise ir_out is demodulated active-low.
`timescale 1ns/1ps
module ir_encoder
    import ir_pkg::*;
#(
    parameter int clk_hz     = 25000000,
    parameter int carrier_hz = 38000,
    parameter int gap_units  = 72
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    output logic        ready,
    input  logic [31:0] command,
    input  logic        rpt,
    output logic        ir_out,
    output logic        busy,
    output logic        done
);
    localparam int UNIT_CYC = unit_cycles(clk_hz);
    localparam int CW       = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
    localparam int UW       = 16;

    ir_state_e      state_q;
    logic [CW-1:0]  cyc_q;
    logic [UW-1:0]  unit_q;
    logic [4:0]     bit_q;
    logic [31:0]    cmd_q;
    logic           rpt_q;

    logic [UW-1:0]  target_units;
    logic           unit_end;
    logic           state_end;
    logic           mark;

    always_comb begin
        target_units = UW'(1);
        case (state_q)
            IR_LEAD_MARK:  target_units = UW'(LEAD_MARK_UNITS);
            IR_LEAD_SPACE: target_units = rpt_q ? UW'(RPT_SPACE_UNITS) : UW'(LEAD_SPACE_UNITS);
            IR_BIT_MARK:   target_units = UW'(BIT_MARK_UNITS);
            IR_BIT_SPACE:  target_units = cmd_q[bit_q] ? UW'(ONE_SPACE_UNITS) : UW'(ZERO_SPACE_UNITS);
            IR_STOP_MARK:  target_units = UW'(STOP_MARK_UNITS);
            IR_GAP:        target_units = UW'(gap_units);
            default:       target_units = UW'(1);
        endcase
    end

    assign unit_end  = (cyc_q == CW'(UNIT_CYC - 1));
    assign state_end = unit_end && (unit_q == target_units - UW'(1));
    assign mark      = (state_q == IR_LEAD_MARK) || (state_q == IR_BIT_MARK) ||
                       (state_q == IR_STOP_MARK);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IR_IDLE;
            cyc_q   <= '0;
            unit_q  <= '0;
            bit_q   <= '0;
            cmd_q   <= '0;
            rpt_q   <= 1'b0;
        end else if (state_q == IR_IDLE) begin
            cyc_q  <= '0;
            unit_q <= '0;
            bit_q  <= '0;
            if (valid) begin
                cmd_q   <= command;
                rpt_q   <= rpt;
                state_q <= IR_LEAD_MARK;
            end
        end else if (!unit_end) begin
            cyc_q <= cyc_q + CW'(1);
        end else if (!state_end) begin
            cyc_q  <= '0;
            unit_q <= unit_q + UW'(1);
        end else begin
            cyc_q  <= '0;
            unit_q <= '0;
            case (state_q)
                IR_LEAD_MARK:  state_q <= IR_LEAD_SPACE;
                IR_LEAD_SPACE: state_q <= rpt_q ? IR_STOP_MARK : IR_BIT_MARK;
                IR_BIT_MARK:   state_q <= IR_BIT_SPACE;
                IR_BIT_SPACE: begin
                    // Bit 31 ends the payload; the index is cleared again on the next acceptance.
                    state_q <= (bit_q == 5'd31) ? IR_STOP_MARK : IR_BIT_MARK;
                    bit_q   <= bit_q + 5'd1;
                end
                IR_STOP_MARK:  state_q <= IR_GAP;
                default:       state_q <= IR_IDLE;
            endcase
        end
    end

    assign ready = (state_q == IR_IDLE);
    assign busy  = !ready;
    assign done  = (state_q == IR_STOP_MARK) && state_end;

`ifdef IR_ENCODER_CARRIER_EN
    logic carrier;

    ir_carrier_gen #(
        .car_cyc (clk_hz / carrier_hz)
    ) u_carrier (
        .clk     (clk),
        .rst     (rst),
        .restart (!mark),
        .carrier (carrier)
    );

    assign ir_out = mark && carrier;
`else
    logic [31:0] unused_carrier_hz;
    assign unused_carrier_hz = 32'(carrier_hz);

    assign ir_out = !mark;
`endif

endmodule
